// File: rtl/card_dealer_if.sv
// Request/card bus between the deck source and the player/dealer hand controllers.
// master drives draw/shuffle/seed controls; slave (the dealer) returns card data and strobes.
interface card_dealer_if;
    logic        i_drawReq;
    logic        i_dest;
    logic        i_shuffle;
    logic        i_seedLoad;
    logic [15:0] i_seed;
    logic        o_busy;
    logic        o_addPlayer;
    logic        o_addDealer;
    logic [3:0]  o_cardValue;
    logic [3:0]  o_cardRank;
    logic [1:0]  o_cardSuit;
    logic [5:0]  o_cardsRemaining;
    logic        o_deckEmpty;
    logic        o_error;

    modport master (
        output i_drawReq, i_dest, i_shuffle, i_seedLoad, i_seed,
        input  o_busy, o_addPlayer, o_addDealer, o_cardValue, o_cardRank,
               o_cardSuit, o_cardsRemaining, o_deckEmpty, o_error
    );

    modport slave (
        input  i_drawReq, i_dest, i_shuffle, i_seedLoad, i_seed,
        output o_busy, o_addPlayer, o_addDealer, o_cardValue, o_cardRank,
               o_cardSuit, o_cardsRemaining, o_deckEmpty, o_error
    );
endinterface

// File: rtl/card_dealer.sv
// Single-deck card source: LFSR pick + linear probe over a 52-bit used mask (CARD_DEALER_STACKED_EN: sequential pick).
// Latency: add strobe 3..54 cycles after an accepted request; o_error one cycle after a rejected one.
// Backpressure: o_busy high while drawing; requests are ignored until it drops, shuffles are held until idle.
module card_dealer #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input logic          i_clk,
    input logic          i_reset,
    card_dealer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PICK, PROBE, DEAL} state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q;
    logic [51:0] used_q;
    logic [5:0]  idx_q;
    logic [5:0]  rem_q;
    logic        dest_q;
    logic        shuffle_pend_q;
    logic        add_player_q, add_dealer_q, error_q;
    logic [3:0]  value_q, rank_q;
    logic [1:0]  suit_q;

    logic        apply_shuffle, accept, deal, error_d;
    logic [5:0]  pick_idx, next_idx, suit_base;
    logic [1:0]  suit_d;
    logic [3:0]  rank_d;

    assign next_idx = (idx_q == 6'd51) ? 6'd0 : idx_q + 6'd1;

`ifdef CARD_DEALER_STACKED_EN
    logic [5:0] ptr_q;
    assign pick_idx = ptr_q;
`else
    // 64-entry LFSR window folded onto 52 slots; the probe absorbs the resulting bias.
    assign pick_idx = (lfsr_q[5:0] >= 6'd52) ? lfsr_q[5:0] - 6'd12 : lfsr_q[5:0];
`endif

    always_comb begin
        state_d       = state_q;
        apply_shuffle = 1'b0;
        accept        = 1'b0;
        deal          = 1'b0;
        error_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_shuffle || shuffle_pend_q) begin
                    apply_shuffle = 1'b1;
                end else if (bus.i_drawReq) begin
                    if (rem_q == 6'd0) begin
                        error_d = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = PICK;
                    end
                end
            end
            PICK:  state_d = PROBE;
            PROBE: begin
                if (!used_q[idx_q]) begin
                    deal    = 1'b1;
                    state_d = DEAL;
                end
            end
            DEAL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (idx_q >= 6'd39) begin
            suit_d    = 2'd3;
            suit_base = 6'd39;
        end else if (idx_q >= 6'd26) begin
            suit_d    = 2'd2;
            suit_base = 6'd26;
        end else if (idx_q >= 6'd13) begin
            suit_d    = 2'd1;
            suit_base = 6'd13;
        end else begin
            suit_d    = 2'd0;
            suit_base = 6'd0;
        end
        rank_d = 4'(idx_q - suit_base) + 4'd1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lfsr_q <= SEED;
        end else if (bus.i_seedLoad) begin
            lfsr_q <= (bus.i_seed == 16'd0) ? SEED : bus.i_seed;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q        <= IDLE;
            used_q         <= '0;
            idx_q          <= '0;
            rem_q          <= 6'd52;
            dest_q         <= 1'b0;
            shuffle_pend_q <= 1'b0;
            add_player_q   <= 1'b0;
            add_dealer_q   <= 1'b0;
            error_q        <= 1'b0;
            value_q        <= '0;
            rank_q         <= '0;
            suit_q         <= '0;
        end else begin
            state_q      <= state_d;
            error_q      <= error_d;
            add_player_q <= deal && !dest_q;
            add_dealer_q <= deal && dest_q;
            if (accept) dest_q <= bus.i_dest;
            if (state_q == PICK) begin
                idx_q <= pick_idx;
            end else if (state_q == PROBE && !deal) begin
                idx_q <= next_idx;
            end
            if (apply_shuffle) begin
                shuffle_pend_q <= 1'b0;
            end else if (bus.i_shuffle && state_q != IDLE) begin
                shuffle_pend_q <= 1'b1;
            end
            if (apply_shuffle) begin
                used_q <= '0;
                rem_q  <= 6'd52;
            end else if (deal) begin
                used_q[idx_q] <= 1'b1;
                rem_q         <= rem_q - 6'd1;
                rank_q        <= rank_d;
                suit_q        <= suit_d;
                value_q       <= (rank_d > 4'd10) ? 4'd10 : rank_d;
            end
        end
    end

`ifdef CARD_DEALER_STACKED_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ptr_q <= '0;
        end else if (apply_shuffle) begin
            ptr_q <= '0;
        end else if (deal) begin
            ptr_q <= next_idx;
        end
    end
`endif

    assign bus.o_busy           = (state_q != IDLE);
    assign bus.o_addPlayer      = add_player_q;
    assign bus.o_addDealer      = add_dealer_q;
    assign bus.o_cardValue      = value_q;
    assign bus.o_cardRank       = rank_q;
    assign bus.o_cardSuit       = suit_q;
    assign bus.o_cardsRemaining = rem_q;
    assign bus.o_deckEmpty      = (rem_q == 6'd0);
    assign bus.o_error          = error_q;
endmodule
